// File: rtl/sched_issue.sv
// sched_issue -- single-entry in-order issue stage for the Raisin64 core.
//
// Holds one decoded instruction and issues it to a free execution unit of
// the matching class once its operands and destinations are free. A
// per-register scoreboard covers read-after-write and write-after-write
// hazards. ALUs are picked round-robin. Undecodable instructions are dropped
// and reported on the illegal pulse.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       discard the held instruction
//   in_valid / in_ready         decode handshake (in_ready is combinational)
//   in_type, in_unit            decoded type bit and unit field
//   in_r1, in_r2                source registers
//   in_rd, in_rd2               destination registers (rd2 for advint only)
//   wb_valid, wb_rn             finish ports, port i at wb_rn[i*REG_BITS +: REG_BITS]
//   alu_busy, *_busy            execution-unit busy flags
//   alu_en, *_en                registered one-cycle issue pulses
//   iss_rd, iss_rd2             destinations of the issued instruction, else 0
//   illegal                     registered pulse for a dropped instruction
//   sb_busy                     scoreboard contents (bit 0 always 0)
module sched_issue #(
  parameter int REG_BITS = 6,
  parameter int NUM_ALU  = 2,
  parameter int NUM_WB   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_type,
  input  logic [2:0]                   in_unit,
  input  logic [REG_BITS-1:0]          in_r1,
  input  logic [REG_BITS-1:0]          in_r2,
  input  logic [REG_BITS-1:0]          in_rd,
  input  logic [REG_BITS-1:0]          in_rd2,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*REG_BITS-1:0]   wb_rn,
  input  logic [NUM_ALU-1:0]           alu_busy,
  input  logic                         advint_busy,
  input  logic                         mem_busy,
  input  logic                         branch_busy,
  output logic [NUM_ALU-1:0]           alu_en,
  output logic                         advint_en,
  output logic                         mem_en,
  output logic                         branch_en,
  output logic [REG_BITS-1:0]          iss_rd,
  output logic [REG_BITS-1:0]          iss_rd2,
  output logic                         illegal,
  output logic [(1<<REG_BITS)-1:0]     sb_busy
);

  localparam int NUM_REG = 1 << REG_BITS;
  localparam int PTR_W   = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

  // (base + off) modulo NUM_ALU, for off in [0, NUM_ALU]
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_ALU) begin
      sum = sum - NUM_ALU;
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  logic                hold_valid_r;
  logic                hold_type_r;
  logic [2:0]          hold_unit_r;
  logic [REG_BITS-1:0] hold_r1_r, hold_r2_r, hold_rd_r, hold_rd2_r;
  logic [NUM_REG-1:0]  sb_r;
  logic [PTR_W-1:0]    rr_ptr_r;

  logic                cls_alu_s, cls_adv_s, cls_mem_s, cls_br_s, cls_none_s;
  logic [NUM_REG-1:0]  wb_clr_s, eff_busy_s, sb_next_s;
  logic                alu_found_s;
  logic [PTR_W-1:0]    alu_gnt_s;
  logic [NUM_ALU-1:0]  alu_onehot_s;
  logic                hazard_s, unit_free_s, issue_s, drop_s, leave_s;

  // Unit class of the held instruction
  always_comb begin
    cls_alu_s  = ~hold_unit_r[2];
    cls_adv_s  = ~hold_type_r & (hold_unit_r == 3'd4);
    cls_mem_s  = hold_type_r & ((hold_unit_r == 3'd4) | (hold_unit_r == 3'd5) | (hold_unit_r == 3'd6));
    cls_br_s   = (hold_unit_r == 3'd7);
    cls_none_s = ~hold_type_r & ((hold_unit_r == 3'd5) | (hold_unit_r == 3'd6));
  end

  // Registers finishing this cycle; a same-cycle finish bypasses the hazard
  always_comb begin
    wb_clr_s = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i]) begin
        wb_clr_s[wb_rn[i*REG_BITS +: REG_BITS]] = 1'b1;
      end else begin
        wb_clr_s = wb_clr_s;
      end
    end
    eff_busy_s = sb_r & ~wb_clr_s;
  end

  // Round-robin ALU pick: first free ALU at or after rr_ptr
  always_comb begin
    alu_found_s = 1'b0;
    alu_gnt_s   = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      if (!alu_found_s && !alu_busy[wrap_idx(rr_ptr_r, k)]) begin
        alu_found_s = 1'b1;
        alu_gnt_s   = wrap_idx(rr_ptr_r, k);
      end else begin
        alu_found_s = alu_found_s;
      end
    end
    for (int k = 0; k < NUM_ALU; k++) begin
      alu_onehot_s[k] = (int'(alu_gnt_s) == k);
    end
  end

  // Issue / drop decision and decode handshake
  always_comb begin
    hazard_s = eff_busy_s[hold_r1_r] | eff_busy_s[hold_r2_r] | eff_busy_s[hold_rd_r] |
               (cls_adv_s & eff_busy_s[hold_rd2_r]);
    unit_free_s = (cls_alu_s & alu_found_s) | (cls_adv_s & ~advint_busy) |
                  (cls_mem_s & ~mem_busy) | (cls_br_s & ~branch_busy);
    issue_s  = hold_valid_r & ~flush & ~cls_none_s & ~hazard_s & unit_free_s;
    drop_s   = hold_valid_r & ~flush & cls_none_s;
    leave_s  = issue_s | drop_s;
    in_ready = ~flush & (~hold_valid_r | leave_s);
  end

  // Next scoreboard: clear finished registers, then set issued destinations
  always_comb begin
    sb_next_s = sb_r & ~wb_clr_s;
    if (issue_s) begin
      sb_next_s[hold_rd_r] = 1'b1;
      if (cls_adv_s) begin
        sb_next_s[hold_rd2_r] = 1'b1;
      end else begin
        sb_next_s = sb_next_s;
      end
    end else begin
      sb_next_s = sb_next_s;
    end
    // r0 is never tracked, which also covers "set only if nonzero"
    sb_next_s[0] = 1'b0;
  end

  // Hold register: flush empties it, otherwise reload on accept or empty on leave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_r <= 1'b0;
      hold_type_r  <= 1'b0;
      hold_unit_r  <= 3'd0;
      hold_r1_r    <= '0;
      hold_r2_r    <= '0;
      hold_rd_r    <= '0;
      hold_rd2_r   <= '0;
    end else if (flush) begin
      hold_valid_r <= 1'b0;
    end else if (in_valid && in_ready) begin
      hold_valid_r <= 1'b1;
      hold_type_r  <= in_type;
      hold_unit_r  <= in_unit;
      hold_r1_r    <= in_r1;
      hold_r2_r    <= in_r2;
      hold_rd_r    <= in_rd;
      hold_rd2_r   <= in_rd2;
    end else if (leave_s) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

  // Scoreboard and round-robin pointer; flush leaves both untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_r     <= '0;
      rr_ptr_r <= '0;
    end else begin
      sb_r <= sb_next_s;
      if (issue_s && cls_alu_s) begin
        rr_ptr_r <= wrap_idx(alu_gnt_s, 1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Registered issue pulses and destinations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_en    <= '0;
      advint_en <= 1'b0;
      mem_en    <= 1'b0;
      branch_en <= 1'b0;
      iss_rd    <= '0;
      iss_rd2   <= '0;
      illegal   <= 1'b0;
    end else begin
      alu_en    <= (issue_s && cls_alu_s) ? alu_onehot_s : '0;
      advint_en <= issue_s & cls_adv_s;
      mem_en    <= issue_s & cls_mem_s;
      branch_en <= issue_s & cls_br_s;
      iss_rd    <= issue_s ? hold_rd_r : '0;
      iss_rd2   <= (issue_s && cls_adv_s) ? hold_rd2_r : '0;
      illegal   <= drop_s;
    end
  end

  assign sb_busy = sb_r;

endmodule
